// File: rtl/mips_store_monitor.sv
// ============================================================================
// Module   : mips_store_monitor
// Purpose  : Logs committed stores from the MIPS Lite core into a FIFO and
//            decides self-test pass/fail (pass-address store or timeout).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mips_store_monitor #(
    parameter int          DEPTH     = 8,
    parameter logic [31:0] PASS_ADDR = 32'd84,
    parameter logic [31:0] PASS_DATA = 32'd7,
    parameter int          TIMEOUT   = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memwrite,
    input  logic [31:0] dataadr,
    input  logic [31:0] writedata,
    input  logic        log_ready,
    output logic        log_valid,
    output logic [31:0] log_addr,
    output logic [31:0] log_data,
    output logic [15:0] store_count,
    output logic        overflow,
    output logic        pass,
    output logic        fail
);

    localparam int          AW       = $clog2(DEPTH);
    localparam logic [15:0] CYC_LAST = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_RUN  = 2'd0,
        S_PASS = 2'd1,
        S_FAIL = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic [15:0] cyc;
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [31:0] mem_addr [DEPTH];
    logic [31:0] mem_data [DEPTH];

    logic store;
    logic empty;
    logic full;
    logic do_pop;
    logic do_push;

    assign store   = memwrite && (state == S_RUN);
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign do_pop  = !empty && log_ready;
    // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
    assign do_push = store && (!full || do_pop);

    assign log_valid = !empty;
    assign log_addr  = empty ? 32'd0 : mem_addr[rd_ptr[AW-1:0]];
    assign log_data  = empty ? 32'd0 : mem_data[rd_ptr[AW-1:0]];
    assign pass      = (state == S_PASS);
    assign fail      = (state == S_FAIL);

    // The pass-address store takes priority over a coincident timeout.
    always_comb begin
        state_nxt = state;
        if (state == S_RUN) begin
            if (store && (dataadr == PASS_ADDR)) begin
                state_nxt = (writedata == PASS_DATA) ? S_PASS : S_FAIL;
            end else if (cyc == CYC_LAST) begin
                state_nxt = S_FAIL;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_RUN;
            cyc         <= 16'd0;
            store_count <= 16'd0;
            overflow    <= 1'b0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
        end else begin
            state <= state_nxt;
            if (state == S_RUN) begin
                cyc <= cyc + 16'd1;
            end
            if (store && (store_count != 16'hFFFF)) begin
                store_count <= store_count + 16'd1;
            end
            if (store && !do_push) begin
                overflow <= 1'b1;
            end
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage needs no reset: entries are only visible behind the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_addr[wr_ptr[AW-1:0]] <= dataadr;
            mem_data[wr_ptr[AW-1:0]] <= writedata;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mips_store_monitor.sv
// ============================================================================
// Module   : tb_mips_store_monitor
// Purpose  : Directed vector table plus hand sequences for mips_store_monitor.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mips_store_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        memwrite = 1'b0;
    logic [31:0] dataadr = 32'd0;
    logic [31:0] writedata = 32'd0;
    logic        log_ready = 1'b0;
    logic        log_valid;
    logic [31:0] log_addr;
    logic [31:0] log_data;
    logic [15:0] store_count;
    logic        overflow;
    logic        pass;
    logic        fail;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mips_store_monitor #(
        .DEPTH     (8),
        .PASS_ADDR (32'd84),
        .PASS_DATA (32'd7),
        .TIMEOUT   (20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .memwrite    (memwrite),
        .dataadr     (dataadr),
        .writedata   (writedata),
        .log_ready   (log_ready),
        .log_valid   (log_valid),
        .log_addr    (log_addr),
        .log_data    (log_data),
        .store_count (store_count),
        .overflow    (overflow),
        .pass        (pass),
        .fail        (fail)
    );

    typedef struct {
        logic        rst;
        logic        mw;
        logic [31:0] a;
        logic [31:0] d;
        logic        rdy;
        logic        e_valid;
        logic [31:0] e_addr;
        logic [31:0] e_data;
        logic [15:0] e_cnt;
        logic        e_pass;
        logic        e_fail;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Leaves the bench at a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        memwrite = 1'b0;
        log_ready = 1'b0;
        reset = 1'b0;
        #2;
        reset = 1'b1;
    endtask

    task automatic cycle(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
        memwrite  = mw;
        dataadr   = a;
        writedata = d;
        log_ready = rdy;
        @(posedge clk);
        @(negedge clk);
        memwrite  = 1'b0;
    endtask

    logic [31:0] last_addr;
    logic [31:0] last_data;
    int          popped;

    initial begin
        tbl[0]  = '{1'b1, 1'b1, 32'h50, 32'h12,   1'b1, 1'b1, 32'h50, 32'h12,   16'd1, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 32'd84, 32'd7,    1'b1, 1'b1, 32'h54, 32'h7,    16'd2, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 32'h60, 32'h1,    1'b1, 1'b0, 32'h0,  32'h0,    16'd2, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0,  32'h0,    16'd2, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 32'd84, 32'd5,    1'b0, 1'b1, 32'h54, 32'h5,    16'd1, 1'b0, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 32'h50, 32'd9,    1'b0, 1'b1, 32'h54, 32'h5,    16'd1, 1'b0, 1'b1};
        tbl[6]  = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0,  32'h0,    16'd1, 1'b0, 1'b1};
        tbl[7]  = '{1'b1, 1'b1, 32'h8,  32'hDEAD, 1'b1, 1'b1, 32'h8,  32'hDEAD, 16'd1, 1'b0, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b0, 1'b1, 32'h8,  32'hDEAD, 16'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 32'hC,  32'h1,    1'b0, 1'b1, 32'h8,  32'hDEAD, 16'd2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b1, 32'hC,  32'h1,    16'd2, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b0, 32'h0,  32'h0,    1'b1, 1'b0, 32'h0,  32'h0,    16'd2, 1'b0, 1'b0};

        // Reset held with memwrite toggling: everything stays zero.
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            memwrite  = ~memwrite;
            dataadr   = 32'd84;
            writedata = 32'd7;
            log_ready = 1'b1;
        end
        @(negedge clk);
        chk("reset_outputs",
            {log_valid, overflow, pass, fail, 28'd0} | {16'd0, store_count} | log_addr | log_data,
            32'd0);

        // Idle timeout: fail rises on exactly the 20th edge.
        memwrite = 1'b0;
        log_ready = 1'b0;
        #2;
        reset = 1'b1;
        for (int i = 0; i < 19; i++) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("timeout_edge19_fail", {31'd0, fail}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        chk("timeout_edge20_fail", {31'd0, fail}, 32'd1);
        chk("timeout_pass", {31'd0, pass}, 32'd0);

        // Vector table.
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            cycle(tbl[i].mw, tbl[i].a, tbl[i].d, tbl[i].rdy);
            chk($sformatf("v%0d_valid", i), {31'd0, log_valid}, {31'd0, tbl[i].e_valid});
            chk($sformatf("v%0d_addr", i), log_addr, tbl[i].e_addr);
            chk($sformatf("v%0d_data", i), log_data, tbl[i].e_data);
            chk($sformatf("v%0d_count", i), {16'd0, store_count}, {16'd0, tbl[i].e_cnt});
            chk($sformatf("v%0d_pass", i), {31'd0, pass}, {31'd0, tbl[i].e_pass});
            chk($sformatf("v%0d_fail", i), {31'd0, fail}, {31'd0, tbl[i].e_fail});
            chk($sformatf("v%0d_ovf", i), {31'd0, overflow}, 32'd0);
        end

        // Overflow: ten stores into an 8-deep FIFO with no consumer.
        do_reset();
        for (int i = 0; i < 10; i++) begin
            cycle(1'b1, 32'(4 * i), 32'(4 * i), 1'b0);
            if (i == 7) chk("ovf_after8", {31'd0, overflow}, 32'd0);
            if (i == 8) chk("ovf_after9", {31'd0, overflow}, 32'd1);
        end
        chk("ovf_flag", {31'd0, overflow}, 32'd1);
        chk("ovf_count", {16'd0, store_count}, 32'd10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("ovf_drain%0d_valid", i), {31'd0, log_valid}, 32'd1);
            chk($sformatf("ovf_drain%0d_addr", i), log_addr, 32'(4 * i));
            chk($sformatf("ovf_drain%0d_data", i), log_data, 32'(4 * i));
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("ovf_drained_valid", {31'd0, log_valid}, 32'd0);

        // Full FIFO with a simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 32'(4 * i), 32'(i), 1'b0);
        end
        chk("full_head", log_addr, 32'd0);
        cycle(1'b1, 32'h100, 32'hAA, 1'b1);
        chk("full_pp_ovf", {31'd0, overflow}, 32'd0);
        chk("full_pp_head", log_addr, 32'd4);
        chk("full_pp_count", {16'd0, store_count}, 32'd9);
        popped = 0;
        last_addr = 32'd0;
        last_data = 32'd0;
        for (int k = 0; k < 20 && log_valid; k++) begin
            last_addr = log_addr;
            last_data = log_data;
            popped++;
            cycle(1'b0, 32'd0, 32'd0, 1'b1);
        end
        chk("full_pp_popped", 32'(popped), 32'd8);
        chk("full_pp_last_addr", last_addr, 32'h100);
        chk("full_pp_last_data", last_data, 32'hAA);
        chk("full_pp_empty", {31'd0, log_valid}, 32'd0);

        // Reset while in PASS with entries queued.
        do_reset();
        cycle(1'b1, 32'h10, 32'd1, 1'b0);
        cycle(1'b1, 32'h14, 32'd2, 1'b0);
        cycle(1'b1, 32'd84, 32'd7, 1'b0);
        chk("mid_pass", {31'd0, pass}, 32'd1);
        chk("mid_count", {16'd0, store_count}, 32'd3);
        chk("mid_head", log_addr, 32'h10);
        reset = 1'b0;
        #1;
        chk("mid_rst_pass", {31'd0, pass}, 32'd0);
        chk("mid_rst_valid", {31'd0, log_valid}, 32'd0);
        chk("mid_rst_count", {16'd0, store_count}, 32'd0);
        chk("mid_rst_addr", log_addr, 32'd0);
        #1;
        reset = 1'b1;
        cycle(1'b1, 32'h50, 32'h12, 1'b0);
        chk("rerun_valid", {31'd0, log_valid}, 32'd1);
        chk("rerun_addr", log_addr, 32'h50);
        chk("rerun_data", log_data, 32'h12);
        chk("rerun_count", {16'd0, store_count}, 32'd1);
        chk("rerun_flags", {30'd0, pass, fail}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
